tuner_sweep_ctrl: RTL

TUNER_SWEEP_CTRL -- requirements
Module: tuner_sweep_ctrl

---
 rtl/wdm_pkg.sv | 21 ++
 rtl/tuner_peak_track.sv | 46 ++++
 rtl/tuner_sweep_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wdm_pkg.sv
// Shared types for the WDM microring tuning controllers.
package wdm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SET     = 4'd1,
        ST_SETTLE  = 4'd2,
        ST_REQ     = 4'd3,
        ST_WAIT    = 4'd4,
        ST_EVAL    = 4'd5,
        ST_NEXT_CH = 4'd6,
        ST_PARK    = 4'd7,
        ST_DONE    = 4'd8
    } sweep_state_e;

    typedef enum logic {
        SWEEP_MODE_MIN_THRU = 1'b0,
        SWEEP_MODE_MAX_DROP = 1'b1
    } sweep_mode_e;

endpackage

// File: rtl/tuner_peak_track.sv
// Tracks the best (code, power) pair of the channel being swept; ties keep the earliest code.
module tuner_peak_track
    import wdm_pkg::*;
#(
    parameter int unsigned DAC_WIDTH = 8,
    parameter int unsigned ADC_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_upd,
    input  logic                 i_first,
    input  logic                 i_mode,
    input  logic [DAC_WIDTH-1:0] i_code,
    input  logic [ADC_WIDTH-1:0] i_pwr,
    output logic [DAC_WIDTH-1:0] o_best_code,
    output logic [ADC_WIDTH-1:0] o_best_pwr
);

    logic [DAC_WIDTH-1:0] code_q;
    logic [ADC_WIDTH-1:0] pwr_q;
    logic                 better_c;

    // Strict comparison so an equal later sample never displaces the record.
    always_comb begin
        better_c = 1'b0;
        if (i_mode == SWEEP_MODE_MAX_DROP) begin
            better_c = (i_pwr > pwr_q);
        end else begin
            better_c = (i_pwr < pwr_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            code_q <= '0;
            pwr_q  <= '0;
        end else if (i_upd && (i_first || better_c)) begin
            code_q <= i_code;
            pwr_q  <= i_pwr;
        end
    end

    assign o_best_code = code_q;
    assign o_best_pwr  = pwr_q;

endmodule

// File: rtl/tuner_sweep_ctrl.sv
// Sweeps microring tuning codes per masked channel and parks each at its best detected power.
// Optional TUNER_SWEEP_TIMEOUT_EN adds a per-point response timeout with sticky o_err_timeout.
module tuner_sweep_ctrl
    import wdm_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned DAC_WIDTH     = 8,
    parameter int unsigned ADC_WIDTH     = 8,
    parameter int unsigned SETTLE_CYCLES = 4
`ifdef TUNER_SWEEP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic [NUM_CH-1:0]             i_ch_mask,
    input  logic                          i_mode,
    input  logic [DAC_WIDTH-1:0]          i_code_start,
    input  logic [DAC_WIDTH-1:0]          i_code_end,
    input  logic [DAC_WIDTH-1:0]          i_code_step,
    output logic [NUM_CH*DAC_WIDTH-1:0]   o_dac_tune,
    output logic [$clog2(NUM_CH)-1:0]     o_pwr_ch,
    output logic                          o_pwr_read_val,
    input  logic                          i_pwr_read_rdy,
    input  logic                          i_pwr_detect_val,
    output logic                          o_pwr_detect_rdy,
    input  logic [ADC_WIDTH-1:0]          i_pwr_detected,
    output logic [NUM_CH*DAC_WIDTH-1:0]   o_best_code,
    output logic [NUM_CH*ADC_WIDTH-1:0]   o_best_pwr,
    output logic [NUM_CH-1:0]             o_ch_locked,
    output logic                          o_busy,
    output logic                          o_done
`ifdef TUNER_SWEEP_TIMEOUT_EN
    ,
    output logic                          o_err_timeout
`endif
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    sweep_state_e                        state_q, state_d;
    logic [CH_W-1:0]                     ch_q, ch_d;
    logic [DAC_WIDTH-1:0]                code_q, code_d;
    logic [DAC_WIDTH-1:0]                start_q, start_d, end_q, end_d, step_q, step_d;
    logic                                mode_q, mode_d;
    logic [NUM_CH-1:0]                   mask_q, mask_d;
    logic                                first_q, first_d;
    logic [SET_W-1:0]                    settle_q, settle_d;
    logic [ADC_WIDTH-1:0]                pwr_q, pwr_d;
    logic [NUM_CH-1:0][DAC_WIDTH-1:0]    dac_q, dac_d, bcode_q, bcode_d;
    logic [NUM_CH-1:0][ADC_WIDTH-1:0]    bpwr_q, bpwr_d;
    logic [NUM_CH-1:0]                   locked_q, locked_d;
    logic                                busy_q, busy_d, done_q, done_d;
    logic                                rd_val_q, rd_val_d, det_rdy_q, det_rdy_d;

    logic [DAC_WIDTH-1:0]                trk_code;
    logic [ADC_WIDTH-1:0]                trk_pwr;
    logic [CH_W-1:0]                     first_ch_c, nxt_ch_c;
    logic                                nxt_found_c;
    logic [DAC_WIDTH-1:0]                step_eff_c;
    logic [DAC_WIDTH:0]                  sum_c;
    logic                                adv_end_c;
    logic                                tmo_hit_c;
    logic                                adv_go, skip_go;

`ifdef TUNER_SWEEP_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;

    assign tmo_hit_c     = ((state_q == ST_REQ) || (state_q == ST_WAIT)) &&
                           (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign o_err_timeout = err_q;
`else
    assign tmo_hit_c = 1'b0;
`endif

    tuner_peak_track #(
        .DAC_WIDTH (DAC_WIDTH),
        .ADC_WIDTH (ADC_WIDTH)
    ) u_peak_track (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_upd       (state_q == ST_EVAL),
        .i_first     (first_q),
        .i_mode      (mode_q),
        .i_code      (code_q),
        .i_pwr       (pwr_q),
        .o_best_code (trk_code),
        .o_best_pwr  (trk_pwr)
    );

    // Lowest requested channel and next higher latched channel; later (lower) hits win.
    always_comb begin
        first_ch_c  = '0;
        nxt_ch_c    = '0;
        nxt_found_c = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_ch_mask[i]) begin
                first_ch_c = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(ch_q))) begin
                nxt_ch_c    = CH_W'(i);
                nxt_found_c = 1'b1;
            end
        end
    end

    // The extra sum bit makes a step past full scale end the channel instead of wrapping.
    assign step_eff_c = (step_q == '0) ? DAC_WIDTH'(1) : step_q;
    assign sum_c      = {1'b0, code_q} + {1'b0, step_eff_c};
    assign adv_end_c  = sum_c[DAC_WIDTH] || (sum_c > {1'b0, end_q});

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        code_d   = code_q;
        start_d  = start_q;
        end_d    = end_q;
        step_d   = step_q;
        mode_d   = mode_q;
        mask_d   = mask_q;
        first_d  = first_q;
        settle_d = settle_q;
        pwr_d    = pwr_q;
        dac_d    = dac_q;
        bcode_d  = bcode_q;
        bpwr_d   = bpwr_q;
        locked_d = locked_q;
        adv_go   = 1'b0;
        skip_go  = 1'b0;
`ifdef TUNER_SWEEP_TIMEOUT_EN
        err_d = err_q;
        tmo_d = ((state_q == ST_REQ) || (state_q == ST_WAIT)) ? (tmo_q + TMO_W'(1)) : '0;
`endif
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        start_d  = i_code_start;
                        end_d    = i_code_end;
                        step_d   = i_code_step;
                        mode_d   = i_mode;
                        mask_d   = i_ch_mask;
                        locked_d = locked_q & ~i_ch_mask;
                        ch_d     = first_ch_c;
                        code_d   = i_code_start;
                        first_d  = 1'b1;
                        state_d  = (i_ch_mask == '0) ? ST_DONE : ST_SET;
`ifdef TUNER_SWEEP_TIMEOUT_EN
                        err_d = 1'b0;
`endif
                    end
                end
                ST_SET: begin
                    dac_d[ch_q] = code_q;
                    settle_d    = SET_W'(SETTLE_CYCLES - 1);
                    state_d     = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = ST_REQ;
                    end else begin
                        settle_d = settle_q - SET_W'(1);
                    end
                end
                ST_REQ: begin
                    if (i_pwr_read_rdy) begin
                        state_d = ST_WAIT;
                    end else if (tmo_hit_c) begin
                        skip_go = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (i_pwr_detect_val) begin
                        pwr_d   = i_pwr_detected;
                        state_d = ST_EVAL;
                    end else if (tmo_hit_c) begin
                        skip_go = 1'b1;
                    end
                end
                ST_EVAL: begin
                    first_d = 1'b0;
                    adv_go  = 1'b1;
                end
                ST_PARK: begin
                    dac_d[ch_q]    = trk_code;
                    bcode_d[ch_q]  = trk_code;
                    bpwr_d[ch_q]   = trk_pwr;
                    locked_d[ch_q] = 1'b1;
                    state_d        = ST_NEXT_CH;
                end
                ST_NEXT_CH: begin
                    if (nxt_found_c) begin
                        ch_d    = nxt_ch_c;
                        code_d  = start_q;
                        first_d = 1'b1;
                        state_d = ST_SET;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase

            // A timed-out point advances like a measured one but leaves the record alone.
            if (adv_go || skip_go) begin
                if (adv_end_c) begin
                    state_d = ST_PARK;
                end else begin
                    code_d  = sum_c[DAC_WIDTH-1:0];
                    state_d = ST_SET;
                end
            end
`ifdef TUNER_SWEEP_TIMEOUT_EN
            if (skip_go) begin
                err_d = 1'b1;
            end
`endif
        end

        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        rd_val_d  = (state_d == ST_REQ);
        det_rdy_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            ch_q      <= '0;
            code_q    <= '0;
            start_q   <= '0;
            end_q     <= '0;
            step_q    <= '0;
            mode_q    <= 1'b0;
            mask_q    <= '0;
            first_q   <= 1'b0;
            settle_q  <= '0;
            pwr_q     <= '0;
            dac_q     <= '0;
            bcode_q   <= '0;
            bpwr_q    <= '0;
            locked_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_val_q  <= 1'b0;
            det_rdy_q <= 1'b0;
`ifdef TUNER_SWEEP_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            code_q    <= code_d;
            start_q   <= start_d;
            end_q     <= end_d;
            step_q    <= step_d;
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            first_q   <= first_d;
            settle_q  <= settle_d;
            pwr_q     <= pwr_d;
            dac_q     <= dac_d;
            bcode_q   <= bcode_d;
            bpwr_q    <= bpwr_d;
            locked_q  <= locked_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_val_q  <= rd_val_d;
            det_rdy_q <= det_rdy_d;
`ifdef TUNER_SWEEP_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    assign o_dac_tune       = dac_q;
    assign o_best_code      = bcode_q;
    assign o_best_pwr       = bpwr_q;
    assign o_ch_locked      = locked_q;
    assign o_pwr_ch         = ch_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_pwr_read_val   = rd_val_q;
    assign o_pwr_detect_rdy = det_rdy_q;

endmodule
